// File: rtl/multicycle_control_fsm.sv
// Main control FSM for the multicycle RV32I datapath: fetch/decode/execute/memory/write-back sequencing.
// Define ILLEGAL_TRAP_EN to send unrecognised opcodes to a sticky TRAP state instead of retiring them as NOPs.
module multicycle_control_fsm #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       instr_opcode,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_write,
    output logic             imm_latch,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic [1:0]       pc_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             reg_write,
    output logic [1:0]       wb_sel,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired,
    output logic             trap
);

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    state_t     state_q;
    state_t     state_d;
    logic [6:0] opcode_q;
    logic       legal;
    logic       retire;

    always_comb begin
        case (opcode_q)
            OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: legal = 1'b1;
            default:                           legal = 1'b0;
        endcase
    end

    // An instruction completes whenever control returns to FETCH from any post-fetch state.
    assign retire = (state_d == S_FETCH) && (state_q != S_FETCH) && (state_q != S_RESET);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_RESET;
            opcode_q <= 7'd0;
            retired  <= '0;
        end else begin
            state_q <= state_d;
            if (ir_write) begin
                opcode_q <= instr_opcode;
            end
            if (retire) begin
                retired <= retired + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        imm_latch     = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = 2'd0;
        alu_src_a     = 2'd0;
        alu_src_b     = 2'd0;
        alu_op        = 2'd0;
        reg_write     = 1'b0;
        wb_sel        = 2'd0;
        case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'd1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                imm_latch = 1'b1;
                alu_src_b = 2'd2;
                if (legal) begin
                    state_d = S_EXEC;
                end else begin
`ifdef ILLEGAL_TRAP_EN
                    state_d = S_TRAP;
`else
                    state_d = S_FETCH;
`endif
                end
            end
            S_EXEC: begin
                case (opcode_q)
                    OP_R: begin
                        alu_src_a = 2'd1;
                        alu_op    = 2'd2;
                        state_d   = S_WB;
                    end
                    OP_I: begin
                        alu_src_a = 2'd1;
                        alu_src_b = 2'd2;
                        alu_op    = 2'd2;
                        state_d   = S_WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        alu_src_a = 2'd1;
                        alu_src_b = 2'd2;
                        state_d   = S_MEM;
                    end
                    OP_BRANCH: begin
                        alu_src_a     = 2'd1;
                        alu_op        = 2'd1;
                        pc_write_cond = 1'b1;
                        pc_src        = 2'd1;
                        state_d       = S_FETCH;
                    end
                    OP_LUI: begin
                        alu_src_a = 2'd2;
                        alu_src_b = 2'd2;
                        state_d   = S_WB;
                    end
                    OP_AUIPC, OP_JAL: begin
                        alu_src_b = 2'd2;
                        state_d   = S_WB;
                    end
                    OP_JALR: begin
                        alu_src_a = 2'd1;
                        alu_src_b = 2'd2;
                        state_d   = S_WB;
                    end
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_we  = (opcode_q == OP_STORE);
                if (mem_ready) begin
                    state_d = (opcode_q == OP_LOAD) ? S_WB : S_FETCH;
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
                if (opcode_q == OP_LOAD) begin
                    wb_sel = 2'd1;
                end else if (opcode_q == OP_JAL) begin
                    wb_sel   = 2'd2;
                    pc_write = 1'b1;
                    pc_src   = 2'd1;
                end else if (opcode_q == OP_JALR) begin
                    wb_sel   = 2'd2;
                    pc_write = 1'b1;
                    pc_src   = 2'd2;
                end
            end
`ifdef ILLEGAL_TRAP_EN
            S_TRAP: state_d = S_TRAP;
`endif
            default: state_d = S_RESET;
        endcase
    end

    assign state = state_q;

`ifdef ILLEGAL_TRAP_EN
    assign trap = (state_q == S_TRAP);
`else
    assign trap = 1'b0;
`endif

endmodule
